// File: rtl/exe_result_buf_if.sv
// Handshake and forwarding bundle between the ALU result buffer, the memory stage and decode.
// "slave" is the buffer side; "master" is the surrounding pipeline (or a bench).
interface exe_result_buf_if #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_is_word;
  logic [RD_W-1:0]   in_rd;
  logic              in_wen;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_wen;
  logic [DATA_W-1:0] out_pc;
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  modport slave (
    input  flush, in_valid, in_result, in_is_word, in_rd, in_wen, in_pc, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wen, out_pc,
           fwd_valid, fwd_rd, fwd_data, retire_cnt
  );

  modport master (
    output flush, in_valid, in_result, in_is_word, in_rd, in_wen, in_pc, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wen, out_pc,
           fwd_valid, fwd_rd, fwd_data, retire_cnt
  );
endinterface

// File: rtl/exe_result_buf.sv
// Execute-stage result buffer: W-op formatting at capture, 2-entry skid buffer toward
// the memory stage, youngest-entry forwarding to decode and a retired-handshake counter.
module exe_result_buf #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            resetn,
  exe_result_buf_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic [DATA_W-1:0] pc;
  } ent_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state, state_nxt;
  ent_t             main_q, skid_q, main_nxt, skid_nxt, in_ent, young;
  logic             rdy, vld, push, pop;
  logic [CNT_W-1:0] cnt_q;

  // x0 is hardwired, so a write to it is dropped here rather than downstream.
  always_comb begin
    in_ent.result = bus.in_is_word ? {{(DATA_W-32){bus.in_result[31]}}, bus.in_result[31:0]}
                                   : bus.in_result;
    in_ent.rd     = bus.in_rd;
    in_ent.wen    = bus.in_wen & (bus.in_rd != '0);
    in_ent.pc     = bus.in_pc;
  end

  // in_ready comes from state only, so there is no comb path from out_ready.
  assign rdy  = resetn & (state != TWO);
  assign vld  = (state != EMPTY);
  assign push = bus.in_valid & rdy;
  assign pop  = vld & bus.out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt = ONE;
          main_nxt  = in_ent;
        end
        ONE: begin
          if (push && !pop) begin
            state_nxt = TWO;
            skid_nxt  = in_ent;
          end else if (pop && !push) begin
            state_nxt = EMPTY;
          end else if (push && pop) begin
            main_nxt  = in_ent;
          end
        end
        TWO: if (pop) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // A pop that coincides with a flush still retired, so it is counted.
  always_ff @(posedge clk) begin
    if (!resetn)  cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 1'b1;
  end

  assign young = (state == TWO) ? skid_q : main_q;

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = vld;
  assign bus.out_result = main_q.result;
  assign bus.out_rd     = main_q.rd;
  assign bus.out_wen    = main_q.wen;
  assign bus.out_pc     = main_q.pc;
  assign bus.fwd_valid  = vld & young.wen;
  assign bus.fwd_rd     = young.rd;
  assign bus.fwd_data   = young.result;
  assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_exe_result_buf.sv
// Directed bench for exe_result_buf: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_exe_result_buf;
  localparam int DW = 64, RW = 5, CW = 4;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  exe_result_buf_if #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) bus ();
  exe_result_buf #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  mcnt = '0;
  int          checks = 0, failures = 0;
  bit          chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two formatted entries.
  always @(posedge clk) begin
    ent_t e;
    bit   push, pop;
    if (!resetn) begin
      q.delete();
      mcnt = '0;
    end else begin
      push = bus.in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && bus.out_ready;
      if (pop) mcnt = mcnt + 4'd1;
      e.res = bus.in_is_word ? 64'(signed'(bus.in_result[31:0])) : bus.in_result;
      e.rd  = bus.in_rd;
      e.wen = bus.in_wen && (bus.in_rd != 0);
      e.pc  = bus.in_pc;
      if (bus.flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", bus.in_ready, resetn && q.size() < 2);
      chk("out_valid", bus.out_valid, q.size() > 0);
      chk("retire_cnt", bus.retire_cnt, mcnt);
      if (q.size() > 0) begin
        chk("out_result", bus.out_result, q[0].res);
        chk("out_rd", bus.out_rd, q[0].rd);
        chk("out_wen", bus.out_wen, q[0].wen);
        chk("out_pc", bus.out_pc, q[0].pc);
        chk("fwd_valid", bus.fwd_valid, q[$].wen);
        if (q[$].wen) begin
          chk("fwd_rd", bus.fwd_rd, q[$].rd);
          chk("fwd_data", bus.fwd_data, q[$].res);
        end
      end else begin
        chk("fwd_valid_empty", bus.fwd_valid, 1'b0);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic v, input logic [63:0] r, input logic w,
                     input logic [4:0] rd, input logic wen, input logic [63:0] pc);
    bus.in_valid   = v;
    bus.in_result  = r;
    bus.in_is_word = w;
    bus.in_rd      = rd;
    bus.in_wen     = wen;
    bus.in_pc      = pc;
  endtask

  task automatic idle();
    drv(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    cyc(2);
    chk("in_ready_in_reset", bus.in_ready, 1'b0);
    chk_en = 1;
    resetn = 1'b1;
    cyc();

    // Basic push, one-cycle latency, then drained.
    bus.out_ready = 1'b1;
    drv(1'b1, 64'd5, 1'b0, 5'd3, 1'b1, 64'h100);
    cyc();
    idle();
    chk("t1_out_valid", bus.out_valid, 1'b1);
    chk("t1_out_result", bus.out_result, 64'd5);
    chk("t1_out_rd", bus.out_rd, 5'd3);
    cyc();
    chk("t1_out_valid_after", bus.out_valid, 1'b0);
    chk("t1_retire_cnt", bus.retire_cnt, 4'd1);

    // W-op sign extension, negative and with junk upper bits.
    drv(1'b1, 64'h0000_0000_8000_0000, 1'b1, 5'd4, 1'b1, 64'h104);
    cyc();
    drv(1'b1, 64'hDEAD_BEEF_1234_5678, 1'b1, 5'd5, 1'b1, 64'h108);
    chk("t2_wop_neg", bus.out_result, 64'hFFFF_FFFF_8000_0000);
    chk("t2_wop_fwd", bus.fwd_data, 64'hFFFF_FFFF_8000_0000);
    cyc();
    idle();
    chk("t2_wop_pos", bus.out_result, 64'h0000_0000_1234_5678);
    cyc();

    // Backpressure: fill to two, offer a third, hold, then drain in order.
    bus.out_ready = 1'b0;
    drv(1'b1, 64'hA1, 1'b0, 5'd7, 1'b1, 64'h200);
    cyc();
    drv(1'b1, 64'hB2, 1'b0, 5'd8, 1'b1, 64'h204);
    cyc();
    drv(1'b1, 64'hC3, 1'b0, 5'd9, 1'b1, 64'h208);
    cyc();
    chk("t3_in_ready", bus.in_ready, 1'b0);
    chk("t3_out_result", bus.out_result, 64'hA1);
    chk("t3_fwd_rd", bus.fwd_rd, 5'd8);
    idle();
    cyc(2);
    bus.out_ready = 1'b1;
    cyc();
    chk("t3_second", bus.out_result, 64'hB2);
    cyc();
    chk("t3_drained", bus.out_valid, 1'b0);

    // Streaming: push and pop in the same cycle while in ONE.
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 64'h300 + 64'(i), 1'b0, 5'd10 + 5'(i), 1'b1, 64'h300 + 64'(4 * i));
      cyc();
    end
    idle();
    cyc();
    chk("t4_retire_cnt", bus.retire_cnt, 4'd9);

    // Flush in TWO with a push and a pop on the same edge.
    bus.out_ready = 1'b0;
    drv(1'b1, 64'hD1, 1'b0, 5'd11, 1'b1, 64'h400);
    cyc();
    drv(1'b1, 64'hD2, 1'b0, 5'd12, 1'b1, 64'h404);
    cyc();
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drv(1'b1, 64'hD3, 1'b0, 5'd13, 1'b1, 64'h408);
    chk("t5_in_ready_flush", bus.in_ready, 1'b0);
    cyc();
    bus.flush = 1'b0;
    idle();
    chk("t5_out_valid", bus.out_valid, 1'b0);
    chk("t5_fwd_valid", bus.fwd_valid, 1'b0);
    chk("t5_retire_cnt", bus.retire_cnt, 4'd10);
    cyc();

    // rd==0 suppresses the write; then wrap the counter past 15.
    bus.out_ready = 1'b0;
    drv(1'b1, 64'hE0, 1'b0, 5'd0, 1'b1, 64'h500);
    cyc();
    idle();
    chk("t6_out_wen", bus.out_wen, 1'b0);
    chk("t6_fwd_valid", bus.fwd_valid, 1'b0);
    bus.out_ready = 1'b1;
    cyc();
    chk("t6_cnt", bus.retire_cnt, 4'd11);
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 64'h600 + 64'(i), 1'b0, 5'd20, 1'b1, 64'h600);
      cyc();
    end
    idle();
    cyc();
    chk("t6_wrap", bus.retire_cnt, 4'd0);

    // Reset with two entries buffered.
    bus.out_ready = 1'b0;
    drv(1'b1, 64'hF1, 1'b0, 5'd21, 1'b1, 64'h700);
    cyc();
    drv(1'b1, 64'hF2, 1'b1, 5'd22, 1'b1, 64'h704);
    cyc();
    resetn = 1'b0;
    #1;
    chk("t7_in_ready_rst", bus.in_ready, 1'b0);
    cyc();
    chk("t7_out_valid", bus.out_valid, 1'b0);
    chk("t7_out_result", bus.out_result, 64'h0);
    chk("t7_out_rd", bus.out_rd, 5'd0);
    chk("t7_out_wen", bus.out_wen, 1'b0);
    chk("t7_out_pc", bus.out_pc, 64'h0);
    chk("t7_fwd_valid", bus.fwd_valid, 1'b0);
    chk("t7_fwd_rd", bus.fwd_rd, 5'd0);
    chk("t7_fwd_data", bus.fwd_data, 64'h0);
    chk("t7_retire_cnt", bus.retire_cnt, 4'd0);
    idle();
    resetn = 1'b1;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
